// File: rtl/order_reader.sv
// order_reader: streams a list of image indices held in a 1-cycle-latency RAM
// out through a valid/ready port, buffered by a 2-entry skid FIFO.
// Optional build macro: ORDER_READER_RANGE_CHECK_EN enables the sticky
// err_index flag for indices >= the latched entry count.
module order_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  num_images,
    input  logic [11:0] base_addr,
    output logic [11:0] rd_A,
    output logic        rd_CSB,
    output logic        rd_OEB,
    output logic        rd_WEB,
    input  logic [31:0] rd_O,
    output logic [8:0]  out_index,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err_index
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [8:0]  num_q;
    logic [11:0] base_q;
    logic [8:0]  rd_cnt;
    logic [8:0]  wr_cnt;
    logic        in_flight;
    logic [8:0]  fifo_mem [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        accept, issue, push, pop;
    logic [2:0]  level;
    logic        unused_rd_hi;

    // Only the low 9 bits of a RAM word carry the index.
    assign unused_rd_hi = ^rd_O[31:9];

    assign accept    = (state == IDLE) && start;
    assign push      = in_flight;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_index = out_valid ? fifo_mem[rd_ptr] : 9'd0;
    // The head entry's ordinal equals the number of transfers completed so far.
    assign out_last  = out_valid && (wr_cnt == num_q - 9'd1);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign rd_WEB    = 1'b1;

    // Slots the FIFO must still hold once this cycle's pop and the pending
    // read land; a new read is allowed only if that leaves room for it.
    assign level = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};

    // Next-state decode and RAM read issue.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave one unassigned (no latches).
        state_nxt = state;
        issue     = 1'b0;
        rd_A      = 12'd0;
        rd_CSB    = 1'b1;
        rd_OEB    = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_nxt = (num_images == 9'd0) ? DONE : FETCH;
            end
            FETCH: begin
                if (rd_cnt == num_q) begin
                    state_nxt = DRAIN;
                end else if (level < 3'd2) begin
                    issue  = 1'b1;
                    rd_A   = base_q + {3'b000, rd_cnt};
                    rd_CSB = 1'b0;
                    rd_OEB = 1'b0;
                end
            end
            DRAIN: begin
                if (pop && (wr_cnt + 9'd1 == num_q)) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Latched parameters, read/transfer counters and the in-flight flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_q     <= 9'd0;
            base_q    <= 12'd0;
            rd_cnt    <= 9'd0;
            wr_cnt    <= 9'd0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (accept) begin
                num_q  <= num_images;
                base_q <= base_addr;
                rd_cnt <= 9'd0;
                wr_cnt <= 9'd0;
            end else begin
                if (issue) rd_cnt <= rd_cnt + 9'd1;
                if (pop)   wr_cnt <= wr_cnt + 9'd1;
            end
        end
    end

    // Skid FIFO pointers and occupancy; push+pop together keeps occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Skid FIFO storage, written with the RAM word that arrives this cycle.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; out_index is masked while the FIFO is
        // empty, so stale contents are never visible.
        if (push) fifo_mem[wr_ptr] <= rd_O[8:0];
    end

`ifdef ORDER_READER_RANGE_CHECK_EN
    logic err_q;
    logic bad_head;

    assign bad_head  = out_valid && (out_index >= num_q);
    assign err_index = err_q || bad_head;

    // Sticky range error, cleared by the next accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        err_q <= 1'b0;
        else if (accept)   err_q <= 1'b0;
        else if (bad_head) err_q <= 1'b1;
    end
`else
    assign err_index = 1'b0;
`endif

endmodule
